vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the VGA pipeline. Defaults give 1024x768@60
// (XGA, 65 MHz pixel clock). It walks (hcount, vcount) over the full raster,
// decodes blanking and sync for that pixel, and drives rgb to zero so that the
// downstream draw stages can paint over it. It also provides line and frame
// strobes and a completed-frame counter for pacing the game logic.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   en_i           pixel advance enable (1 = advance one pixel this clk)
//   hcount_o       current pixel column, 0..H_TOTAL-1
//   hblnk_o        horizontal blanking (hcount >= H_ACTIVE)
//   hsync_o        horizontal sync, active-high
//   vcount_o       current line, 0..V_TOTAL-1
//   vblnk_o        vertical blanking (vcount >= V_ACTIVE)
//   vsync_o        vertical sync, active-high
//   rgb_o          pixel colour, always 12'h000 here
//   frame_start_o  one-clk strobe when the raster wraps from the last pixel
//                  of the frame back to (0,0)
//   line_start_o   one-clk strobe when hcount wraps to 0
//   frame_cnt_o    completed-frame counter, wraps silently
//
// Sync polarity for the connector is inverted at the top level, not here.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [10:0]       hcount_o,
  output logic              hblnk_o,
  output logic              hsync_o,
  output logic [10:0]       vcount_o,
  output logic              vblnk_o,
  output logic              vsync_o,
  output logic [11:0]       rgb_o,
  output logic              frame_start_o,
  output logic              line_start_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are 11 bits wide; any larger raster would silently alias.
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_raster_too_big
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0]       hcount_q, hcount_d;
  logic [10:0]       vcount_q, vcount_d;
  logic              hblnk_q, hblnk_d;
  logic              hsync_q, hsync_d;
  logic              vblnk_q, vblnk_d;
  logic              vsync_q, vsync_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic h_wrap;
  logic v_wrap;

  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en_i) begin
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
      if (h_wrap) begin
        hcount_d = 11'd0;
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end

    // Decodes come from the next counter values so that, once registered,
    // every field of a cycle describes the same pixel. With en_i low the
    // counters hold and so do the decodes.
    hblnk_d     = (hcount_d >= H_BLNK_BEG);
    hsync_d     = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
    vblnk_d     = (vcount_d >= V_BLNK_BEG);
    vsync_d     = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
    frame_cnt_d = frame_cnt_q + FCNT_W'(frame_start_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hblnk_q       <= 1'b0;
      hsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      hsync_q       <= hsync_d;
      vblnk_q       <= vblnk_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hblnk_o       = hblnk_q;
  assign hsync_o       = hsync_q;
  assign vblnk_o       = vblnk_q;
  assign vsync_o       = vsync_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;
  // Background colour is black; draw stages add content downstream.
  assign rgb_o         = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances: dut_a uses the XGA defaults (line-level checks), dut_s uses
// a tiny 25x10 raster with a 4-bit frame counter so whole frames and the
// counter wrap fit in a short run. A per-cycle reference raster for each
// instance checks every field; directed spot checks use hand-computed values.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic sb_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- dut_a: default XGA timing ----------------
  logic        rst_a, en_a;
  logic [10:0] hcount_a, vcount_a;
  logic        hblnk_a, hsync_a, vblnk_a, vsync_a;
  logic [11:0] rgb_a;
  logic        fs_a, ls_a;
  logic [15:0] fc_a;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en_i(en_a),
    .hcount_o(hcount_a), .hblnk_o(hblnk_a), .hsync_o(hsync_a),
    .vcount_o(vcount_a), .vblnk_o(vblnk_a), .vsync_o(vsync_a),
    .rgb_o(rgb_a), .frame_start_o(fs_a), .line_start_o(ls_a),
    .frame_cnt_o(fc_a)
  );

  // ---------------- dut_s: small 25x10 raster ----------------
  // H: active 16, fp 2, sync 3, bp 4  -> blank 16..24, sync 18..20
  // V: active 6,  fp 1, sync 2, bp 1  -> blank 6..9,   sync 7..8
  logic        rst_s, en_s;
  logic [10:0] hcount_s, vcount_s;
  logic        hblnk_s, hsync_s, vblnk_s, vsync_s;
  logic [11:0] rgb_s;
  logic        fs_s, ls_s;
  logic [3:0]  fc_s;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FCNT_W(4)
  ) dut_s (
    .clk(clk), .rst(rst_s), .en_i(en_s),
    .hcount_o(hcount_s), .hblnk_o(hblnk_s), .hsync_o(hsync_s),
    .vcount_o(vcount_s), .vblnk_o(vblnk_s), .vsync_o(vsync_s),
    .rgb_o(rgb_s), .frame_start_o(fs_s), .line_start_o(ls_s),
    .frame_cnt_o(fc_s)
  );

  // ---------------- reference rasters ----------------
  logic [10:0] ma_h, ma_v, ms_h, ms_v;
  logic        ma_ls, ma_fs, ms_ls, ms_fs;
  logic [15:0] ma_fc;
  logic [3:0]  ms_fc;

  always @(posedge clk) begin
    if (rst_a) begin
      ma_h <= 11'd0; ma_v <= 11'd0; ma_ls <= 1'b0; ma_fs <= 1'b0; ma_fc <= 16'd0;
    end else if (en_a) begin
      ma_ls <= (ma_h == 11'd1343);
      ma_fs <= (ma_h == 11'd1343) && (ma_v == 11'd805);
      if (ma_h == 11'd1343) begin
        ma_h <= 11'd0;
        if (ma_v == 11'd805) begin
          ma_v  <= 11'd0;
          ma_fc <= ma_fc + 16'd1;
        end else begin
          ma_v <= ma_v + 11'd1;
        end
      end else begin
        ma_h <= ma_h + 11'd1;
      end
    end else begin
      ma_ls <= 1'b0;
      ma_fs <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_s) begin
      ms_h <= 11'd0; ms_v <= 11'd0; ms_ls <= 1'b0; ms_fs <= 1'b0; ms_fc <= 4'd0;
    end else if (en_s) begin
      ms_ls <= (ms_h == 11'd24);
      ms_fs <= (ms_h == 11'd24) && (ms_v == 11'd9);
      if (ms_h == 11'd24) begin
        ms_h <= 11'd0;
        if (ms_v == 11'd9) begin
          ms_v  <= 11'd0;
          ms_fc <= ms_fc + 4'd1;
        end else begin
          ms_v <= ms_v + 11'd1;
        end
      end else begin
        ms_h <= ms_h + 11'd1;
      end
    end else begin
      ms_ls <= 1'b0;
      ms_fs <= 1'b0;
    end
  end

  // Per-cycle scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_on) begin
      chk("a_hcount", 32'(hcount_a), 32'(ma_h));
      chk("a_vcount", 32'(vcount_a), 32'(ma_v));
      chk("a_hblnk",  32'(hblnk_a),  32'(ma_h >= 11'd1024));
      chk("a_hsync",  32'(hsync_a),  32'(ma_h >= 11'd1048 && ma_h < 11'd1184));
      chk("a_vblnk",  32'(vblnk_a),  32'(ma_v >= 11'd768));
      chk("a_vsync",  32'(vsync_a),  32'(ma_v >= 11'd771 && ma_v < 11'd777));
      chk("a_rgb",    32'(rgb_a),    32'd0);
      chk("a_ls",     32'(ls_a),     32'(ma_ls));
      chk("a_fs",     32'(fs_a),     32'(ma_fs));
      chk("a_fcnt",   32'(fc_a),     32'(ma_fc));
      chk("s_hcount", 32'(hcount_s), 32'(ms_h));
      chk("s_vcount", 32'(vcount_s), 32'(ms_v));
      chk("s_hblnk",  32'(hblnk_s),  32'(ms_h >= 11'd16));
      chk("s_hsync",  32'(hsync_s),  32'(ms_h >= 11'd18 && ms_h < 11'd21));
      chk("s_vblnk",  32'(vblnk_s),  32'(ms_v >= 11'd6));
      chk("s_vsync",  32'(vsync_s),  32'(ms_v >= 11'd7 && ms_v < 11'd9));
      chk("s_rgb",    32'(rgb_s),    32'd0);
      chk("s_ls",     32'(ls_s),     32'(ms_ls));
      chk("s_fs",     32'(fs_s),     32'(ms_fs));
      chk("s_fcnt",   32'(fc_s),     32'(ms_fc));
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_s = 1'b1; en_s = 1'b0;
    ticks(2);

    // Reset state, directed
    chk("rst_hcount", 32'(hcount_a), 32'd0);
    chk("rst_vcount", 32'(vcount_a), 32'd0);
    chk("rst_blnk",   32'({hblnk_a, hsync_a, vblnk_a, vsync_a}), 32'd0);
    chk("rst_strobe", 32'({fs_a, ls_a}), 32'd0);
    chk("rst_fcnt",   32'(fc_a), 32'd0);
    sb_on = 1'b1;
    rst_a = 1'b0; rst_s = 1'b0;

    // One full line on dut_a, checking blank/sync edges
    en_a = 1'b1;
    ticks(1023);
    chk("h1023_hblnk", 32'(hblnk_a), 32'd0);
    ticks(1);
    chk("h1024_hcount", 32'(hcount_a), 32'd1024);
    chk("h1024_hblnk",  32'(hblnk_a), 32'd1);
    chk("h1024_hsync",  32'(hsync_a), 32'd0);
    ticks(23);
    chk("h1047_hsync",  32'(hsync_a), 32'd0);
    ticks(1);
    chk("h1048_hsync",  32'(hsync_a), 32'd1);
    ticks(135);
    chk("h1183_hsync",  32'(hsync_a), 32'd1);
    ticks(1);
    chk("h1184_hsync",  32'(hsync_a), 32'd0);
    ticks(159);
    chk("h1343_hcount", 32'(hcount_a), 32'd1343);
    chk("h1343_ls",     32'(ls_a), 32'd0);
    ticks(1);
    chk("wrap_hcount",  32'(hcount_a), 32'd0);
    chk("wrap_vcount",  32'(vcount_a), 32'd1);
    chk("wrap_ls",      32'(ls_a), 32'd1);
    chk("wrap_hblnk",   32'(hblnk_a), 32'd0);
    // Strobe still lasts one clk when en drops right after it
    en_a = 1'b0;
    ticks(1);
    chk("hold_ls",      32'(ls_a), 32'd0);
    chk("hold_hcount",  32'(hcount_a), 32'd0);

    // en toggled every clk for two lines' worth of pixels
    for (int i = 0; i < 2 * 1344 * 2; i++) begin
      en_a = (i % 2 == 0);
      ticks(1);
    end
    chk("toggle_hcount", 32'(hcount_a), 32'd0);
    chk("toggle_vcount", 32'(vcount_a), 32'd3);

    // Reset mid-line with en high
    en_a = 1'b1;
    ticks(700);
    chk("pre_rst_hcount", 32'(hcount_a), 32'd700);
    rst_a = 1'b1;
    ticks(1);
    chk("midrst_hcount", 32'(hcount_a), 32'd0);
    chk("midrst_vcount", 32'(vcount_a), 32'd0);
    chk("midrst_fs",     32'(fs_a), 32'd0);
    rst_a = 1'b0;
    ticks(5);
    chk("resume_hcount", 32'(hcount_a), 32'd5);
    en_a = 1'b0;

    // Small raster: one frame, then run to the 4-bit counter wrap
    en_s = 1'b1;
    ticks(249);
    chk("s_last_h",    32'(hcount_s), 32'd24);
    chk("s_last_v",    32'(vcount_s), 32'd9);
    chk("s_last_vblnk",32'(vblnk_s), 32'd1);
    chk("s_last_fs",   32'(fs_s), 32'd0);
    ticks(1);
    chk("s_f1_pos",    32'({hcount_s, vcount_s}), 32'd0);
    chk("s_f1_fs",     32'(fs_s), 32'd1);
    chk("s_f1_ls",     32'(ls_s), 32'd1);
    chk("s_f1_fcnt",   32'(fc_s), 32'd1);
    ticks(1);
    chk("s_f1_fs_off", 32'(fs_s), 32'd0);
    ticks(3748);
    chk("s_f15_fcnt",  32'(fc_s), 32'd15);
    ticks(1);
    chk("s_wrap_fs",   32'(fs_s), 32'd1);
    chk("s_wrap_fcnt", 32'(fc_s), 32'd0);

    // Small raster: reset mid-frame gives no frame strobe
    ticks(100);
    chk("s_pre_rst_v", 32'(vcount_s), 32'd4);
    rst_s = 1'b1;
    ticks(1);
    chk("s_rst_pos",   32'({hcount_s, vcount_s}), 32'd0);
    chk("s_rst_fs",    32'(fs_s), 32'd0);
    chk("s_rst_fcnt",  32'(fc_s), 32'd0);
    rst_s = 1'b0;
    ticks(3);

    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
